// File: rtl/game_pkg.sv
// Shared game definitions: sequencer state encoding, widths and a width helper.
package game_pkg;

  localparam int STATE_W = 3;
  localparam int PULSE_W = 1;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_ADVANCE   = 3'd2,
    ST_EVAL      = 3'd3,
    ST_GAME_OVER = 3'd4
  } game_state_e;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_tick_divider.sv
// Divides end-of-frame pulses by a programmable modulus into one-cycle ticks.
module frame_tick_divider #(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             clear_in,
  input  logic             frame_in,
  input  logic [CNT_W-1:0] modulus_in,
  output logic             tick_out
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W:0]   cnt_inc;
  logic             last;

  assign cnt_inc  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  // >= rather than == so a modulus reduced mid-count still terminates promptly
  assign last     = (cnt_inc >= {1'b0, modulus_in});
  assign tick_out = frame_in & last & ~clear_in;

  // Frame counter: cleared on request, wraps to zero on each tick.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q <= '0;
    end else if (clear_in) begin
      cnt_q <= '0;
    end else if (frame_in) begin
      cnt_q <= last ? '0 : cnt_inc[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/wall_round_sequencer.sv
// Wall game round sequencer: countdown, wall advance, evaluation, lives and speed-up.
module wall_round_sequencer
  import game_pkg::*;
#(
  parameter int NUM_WALLS           = 4,
  parameter int GOAL_DEPTH          = 60,
  parameter int MAX_FRAMES_PER_TICK = 15,
  parameter int MIN_FRAMES_PER_TICK = 2,
  parameter int ROUNDS_PER_SPEEDUP  = 2,
  parameter int NUM_LIVES           = 3,
  parameter int COUNTDOWN_FRAMES    = 120,
  parameter int HIT_THRESHOLD       = 8,
  parameter int EVAL_TIMEOUT_FRAMES = 4,
  localparam int WIDX_W             = clog2_min1(NUM_WALLS),
  localparam int LIVES_W            = clog2_min1(NUM_LIVES + 1)
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               start_in,
  input  logic               new_frame_in,
  input  logic [15:0]        hit_count_in,
  input  logic               hit_valid_in,
  output logic [7:0]         wall_depth_out,
  output logic [WIDX_W-1:0]  wall_idx_out,
  output logic [7:0]         round_out,
  output logic [15:0]        score_out,
  output logic [LIVES_W-1:0] lives_out,
  output logic [STATE_W-1:0] state_out,
  output logic [PULSE_W-1:0] wall_tick_out,
  output logic [PULSE_W-1:0] eval_req_out,
  output logic [PULSE_W-1:0] new_round_out
);

  logic rst_meta, rst_sync_n;

  game_state_e        state_q, state_d;
  logic [7:0]         round_q, round_d, depth_q, depth_d, fpt_q, fpt_d, speed_q, speed_d;
  logic [15:0]        score_q, score_d, phase_q, phase_d;
  logic [LIVES_W-1:0] lives_q, lives_d, lives_left;
  logic [WIDX_W-1:0]  widx_q, widx_d;
  logic               wall_tick_q, wall_tick_d, eval_req_q, eval_req_d, new_round_q, new_round_d;
  logic               tick, resolve, eval_pass;

  // Reset asserts asynchronously, releases two clk_in edges later.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) {rst_sync_n, rst_meta} <= 2'b00;
    else           {rst_sync_n, rst_meta} <= {rst_meta, 1'b1};
  end

  frame_tick_divider #(.CNT_W(8)) u_tick_div (
    .clk_in     (clk_in),
    .rst_n_in   (rst_sync_n),
    .clear_in   (state_q != ST_ADVANCE),
    .frame_in   (new_frame_in),
    .modulus_in (fpt_q),
    .tick_out   (tick)
  );

  // State and game registers.
  always_ff @(posedge clk_in or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q     <= ST_IDLE;
      round_q     <= '0;
      score_q     <= '0;
      lives_q     <= LIVES_W'(NUM_LIVES);
      widx_q      <= '0;
      depth_q     <= '0;
      fpt_q       <= 8'(MAX_FRAMES_PER_TICK);
      phase_q     <= '0;
      speed_q     <= '0;
      wall_tick_q <= 1'b0;
      eval_req_q  <= 1'b0;
      new_round_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      widx_q      <= widx_d;
      depth_q     <= depth_d;
      fpt_q       <= fpt_d;
      phase_q     <= phase_d;
      speed_q     <= speed_d;
      wall_tick_q <= wall_tick_d;
      eval_req_q  <= eval_req_d;
      new_round_q <= new_round_d;
    end
  end

  // Next-state, round bookkeeping and pulse generation.
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    score_d     = score_q;
    lives_d     = lives_q;
    widx_d      = widx_q;
    depth_d     = depth_q;
    fpt_d       = fpt_q;
    phase_d     = phase_q;
    speed_d     = speed_q;
    wall_tick_d = 1'b0;
    eval_req_d  = 1'b0;
    new_round_d = 1'b0;
    resolve     = 1'b0;
    eval_pass   = 1'b0;
    lives_left  = lives_q;
    unique case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_in) begin
          state_d = ST_COUNTDOWN;
          round_d = '0;
          score_d = '0;
          lives_d = LIVES_W'(NUM_LIVES);
          widx_d  = '0;
          depth_d = '0;
          fpt_d   = 8'(MAX_FRAMES_PER_TICK);
          phase_d = '0;
          speed_d = '0;
        end
      end
      ST_COUNTDOWN: begin
        if (new_frame_in) begin
          if (phase_q == 16'(COUNTDOWN_FRAMES - 1)) begin
            state_d = ST_ADVANCE;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 16'd1;
          end
        end
      end
      ST_ADVANCE: begin
        if (tick) begin
          depth_d     = depth_q + 8'd1;
          wall_tick_d = 1'b1;
          if (depth_q == 8'(GOAL_DEPTH - 1)) begin
            state_d    = ST_EVAL;
            eval_req_d = 1'b1;
            phase_d    = '0;
          end
        end
      end
      ST_EVAL: begin
        // A score result takes precedence over a timeout frame in the same cycle
        if (hit_valid_in) begin
          resolve   = 1'b1;
          eval_pass = (hit_count_in <= 16'(HIT_THRESHOLD));
        end else if (new_frame_in) begin
          if (phase_q == 16'(EVAL_TIMEOUT_FRAMES - 1)) resolve = 1'b1;
          else                                          phase_d = phase_q + 16'd1;
        end
        if (resolve) begin
          phase_d = '0;
          if (eval_pass) begin
            if (score_q != '1) score_d = score_q + 16'd1;
          end else if (lives_q != '0) begin
            lives_left = lives_q - LIVES_W'(1);
          end
          lives_d = lives_left;
          if (lives_left == '0) begin
            state_d = ST_GAME_OVER;
          end else begin
            state_d     = ST_COUNTDOWN;
            new_round_d = 1'b1;
            depth_d     = '0;
            if (round_q != '1) round_d = round_q + 8'd1;
            widx_d = (widx_q == WIDX_W'(NUM_WALLS - 1)) ? '0 : widx_q + WIDX_W'(1);
            if (speed_q == 8'(ROUNDS_PER_SPEEDUP - 1)) begin
              speed_d = '0;
              if (fpt_q > 8'(MIN_FRAMES_PER_TICK)) fpt_d = fpt_q - 8'd1;
            end else begin
              speed_d = speed_q + 8'd1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign state_out      = state_q;
  assign wall_depth_out = depth_q;
  assign wall_idx_out   = widx_q;
  assign round_out      = round_q;
  assign score_out      = score_q;
  assign lives_out      = lives_q;
  assign wall_tick_out  = wall_tick_q;
  assign eval_req_out   = eval_req_q;
  assign new_round_out  = new_round_q;

endmodule
